// File: rtl/vram_cpu_port_sched.sv
// ---------------------------------------------------------------------------
// vram_cpu_port_sched
//
// Queues Z80-side VRAM port traffic (data writes, address sets, read
// prefetches) and hands it to the VRAM access arbiter in strict program
// order. Only one arbiter transaction is outstanding at a time, so the
// arbiter can never reorder CPU accesses. This block also owns the
// read-ahead data latch that the CPU reads from.
//
// Ports
//   CLK21M, RESET                 system clock, synchronous active-high reset
//   cpu_wr_strobe / cpu_wr_data   write a byte at the current VRAM pointer
//   cpu_addr_strobe / cpu_addr    load the VRAM pointer
//   cpu_addr_read                 with cpu_addr_strobe: read-mode set, prefetch
//   cpu_rd_strobe                 CPU consumed cpu_rd_data, prefetch next byte
//   cpu_rd_data                   read-ahead latch
//   cpu_wait                      queue full or prefetch outstanding
//   cpu_err                       sticky: a strobe was dropped
//   VDPVRAMWRREQ/ACK              write channel toggle handshake
//   VDPVRAMACCESSDATA             write data to the arbiter
//   VDPVRAMRDREQ/ACK              read channel toggle handshake
//   VDPVRAMADDRSETREQ/ACK         address-set channel toggle handshake
//   VDPVRAMACCESSADDRTMP          address to the arbiter
//   vram_rd_valid / vram_rd_data  read byte returned by memory
// ---------------------------------------------------------------------------
module vram_cpu_port_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK21M,
   input  logic        RESET,
   input  logic        cpu_wr_strobe,
   input  logic [7:0]  cpu_wr_data,
   input  logic        cpu_addr_strobe,
   input  logic [17:0] cpu_addr,
   input  logic        cpu_addr_read,
   input  logic        cpu_rd_strobe,
   output logic [7:0]  cpu_rd_data,
   output logic        cpu_wait,
   output logic        cpu_err,
   output logic        VDPVRAMWRREQ,
   input  logic        VDPVRAMWRACK,
   output logic [7:0]  VDPVRAMACCESSDATA,
   output logic        VDPVRAMRDREQ,
   input  logic        VDPVRAMRDACK,
   output logic        VDPVRAMADDRSETREQ,
   input  logic        VDPVRAMADDRSETACK,
   output logic [17:0] VDPVRAMACCESSADDRTMP,
   input  logic        vram_rd_valid,
   input  logic [7:0]  vram_rd_data
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      CMD_WR   = 2'd0,
      CMD_ASET = 2'd1,
      CMD_RD   = 2'd2
   } cmd_t;

   typedef struct packed {
      cmd_t        kind;
      logic        rd_flag;
      logic [17:0] payload;
   } entry_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DATA = 2'd2
   } state_t;

   state_t      state, state_nxt;

   entry_t      fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        fifo_full, fifo_empty;
   entry_t      head;
   logic        head_is_read;

   entry_t      push_entry;
   logic        strobe_any, collision, push, push_is_read;
   logic        pop, pop_is_read, rd_land;
   logic        acks_idle;

   // Reads waiting in the queue (RD entries and read-mode ASET entries).
   logic [AW:0] rd_cnt;
   logic        inflight_rd;
   logic        rd_ready;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty   = (wr_ptr == rd_ptr);
   assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head         = fifo_mem[rd_ptr[AW-1:0]];
   assign head_is_read = (head.kind == CMD_RD) ||
                         ((head.kind == CMD_ASET) && head.rd_flag);

   assign acks_idle = (VDPVRAMWRREQ == VDPVRAMWRACK) &&
                      (VDPVRAMRDREQ == VDPVRAMRDACK) &&
                      (VDPVRAMADDRSETREQ == VDPVRAMADDRSETACK);

   assign cpu_wait = fifo_full | (!rd_ready & ((rd_cnt != '0) | inflight_rd));

   // ---------------------------------------------------------------------
   // Strobe selection: addr > wr > rd. Fullness is judged before any pop in
   // the same cycle, so a strobe arriving while full is always dropped.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      push_entry = '0;
      strobe_any = cpu_addr_strobe | cpu_wr_strobe | cpu_rd_strobe;
      collision  = (cpu_addr_strobe & cpu_wr_strobe) |
                   (cpu_addr_strobe & cpu_rd_strobe) |
                   (cpu_wr_strobe & cpu_rd_strobe);
      if (cpu_addr_strobe) begin
         push_entry.kind    = CMD_ASET;
         push_entry.rd_flag = cpu_addr_read;
         push_entry.payload = cpu_addr;
      end else if (cpu_wr_strobe) begin
         push_entry.kind    = CMD_WR;
         push_entry.payload = {10'd0, cpu_wr_data};
      end else begin
         push_entry.kind    = CMD_RD;
      end
   end

   assign push         = strobe_any & !fifo_full;
   assign push_is_read = push & ((push_entry.kind == CMD_RD) ||
                                 ((push_entry.kind == CMD_ASET) && push_entry.rd_flag));
   assign pop_is_read  = pop & head_is_read;

   // ---------------------------------------------------------------------
   // Issue FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK21M) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register sees the pre-edge value of every other register.
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      rd_land   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (acks_idle) state_nxt = inflight_rd ? ST_WAIT_DATA : ST_IDLE;
         end
         ST_WAIT_DATA: begin
            if (vram_rd_valid) begin
               rd_land   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: the queue storage carries no reset; only the pointers decide
   // which entries are live, so stale contents are never observed.
   always_ff @(posedge CLK21M) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
   end

   always_ff @(posedge CLK21M) begin
      if (RESET) begin
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         rd_cnt               <= '0;
         inflight_rd          <= 1'b0;
         rd_ready             <= 1'b0;
         cpu_rd_data          <= 8'h00;
         cpu_err              <= 1'b0;
         VDPVRAMWRREQ         <= 1'b0;
         VDPVRAMRDREQ         <= 1'b0;
         VDPVRAMADDRSETREQ    <= 1'b0;
         VDPVRAMACCESSDATA    <= 8'h00;
         VDPVRAMACCESSADDRTMP <= 18'h0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;

         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            inflight_rd <= head_is_read;
            case (head.kind)
               CMD_WR: begin
                  VDPVRAMACCESSDATA <= head.payload[7:0];
                  VDPVRAMWRREQ      <= ~VDPVRAMWRREQ;
               end
               CMD_ASET: begin
                  VDPVRAMACCESSADDRTMP <= head.payload;
                  VDPVRAMADDRSETREQ    <= ~VDPVRAMADDRSETREQ;
                  // A read-mode set is consumed by the arbiter inside its
                  // read slot, so both requests go out together.
                  if (head.rd_flag) VDPVRAMRDREQ <= ~VDPVRAMRDREQ;
               end
               CMD_RD: begin
                  VDPVRAMRDREQ <= ~VDPVRAMRDREQ;
               end
               default: ;
            endcase
         end

         if (rd_land) begin
            cpu_rd_data <= vram_rd_data;
            rd_ready    <= 1'b1;
            inflight_rd <= 1'b0;
         end

         // A newly queued read invalidates the latch even if an older read
         // lands in the same cycle.
         if (push_is_read) rd_ready <= 1'b0;

         if (collision | (strobe_any & fifo_full)) cpu_err <= 1'b1;

         rd_cnt <= rd_cnt + (AW+1)'(push_is_read) - (AW+1)'(pop_is_read);
      end
   end

endmodule

// File: tb/tb_vram_cpu_port_sched.sv
module tb_vram_cpu_port_sched;

   localparam int DEPTH = 4;

   logic        CLK21M = 1'b0;
   logic        RESET  = 1'b1;
   logic        cpu_wr_strobe = 1'b0;
   logic [7:0]  cpu_wr_data = '0;
   logic        cpu_addr_strobe = 1'b0;
   logic [17:0] cpu_addr = '0;
   logic        cpu_addr_read = 1'b0;
   logic        cpu_rd_strobe = 1'b0;
   logic [7:0]  cpu_rd_data;
   logic        cpu_wait, cpu_err;
   logic        VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ;
   logic        VDPVRAMWRACK = 1'b0, VDPVRAMRDACK = 1'b0, VDPVRAMADDRSETACK = 1'b0;
   logic [7:0]  VDPVRAMACCESSDATA;
   logic [17:0] VDPVRAMACCESSADDRTMP;
   logic        vram_rd_valid = 1'b0;
   logic [7:0]  vram_rd_data = '0;

   always #5 CLK21M = ~CLK21M;

   vram_cpu_port_sched #(.FIFO_DEPTH(DEPTH)) dut (
      .CLK21M(CLK21M), .RESET(RESET),
      .cpu_wr_strobe(cpu_wr_strobe), .cpu_wr_data(cpu_wr_data),
      .cpu_addr_strobe(cpu_addr_strobe), .cpu_addr(cpu_addr),
      .cpu_addr_read(cpu_addr_read), .cpu_rd_strobe(cpu_rd_strobe),
      .cpu_rd_data(cpu_rd_data), .cpu_wait(cpu_wait), .cpu_err(cpu_err),
      .VDPVRAMWRREQ(VDPVRAMWRREQ), .VDPVRAMWRACK(VDPVRAMWRACK),
      .VDPVRAMACCESSDATA(VDPVRAMACCESSDATA),
      .VDPVRAMRDREQ(VDPVRAMRDREQ), .VDPVRAMRDACK(VDPVRAMRDACK),
      .VDPVRAMADDRSETREQ(VDPVRAMADDRSETREQ), .VDPVRAMADDRSETACK(VDPVRAMADDRSETACK),
      .VDPVRAMACCESSADDRTMP(VDPVRAMACCESSADDRTMP),
      .vram_rd_valid(vram_rd_valid), .vram_rd_data(vram_rd_data)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // kind: 0 = write, 1 = address set, 2 = read prefetch
   typedef struct { int kind; bit rdf; logic [17:0] pay; } cmd_s;
   cmd_s        m_q[$];
   bit          m_busy, m_wait_data, m_inflight_rd, m_rd_ready, m_err;
   logic        m_wrreq, m_rdreq, m_asreq;
   logic [7:0]  m_data, m_rd_data;
   logic [17:0] m_addr;

   function automatic bit is_read(input cmd_s c);
      return (c.kind == 2) || (c.kind == 1 && c.rdf);
   endfunction

   function automatic bit m_cpu_wait();
      bit pend = m_inflight_rd;
      foreach (m_q[i]) if (is_read(m_q[i])) pend = 1;
      return (m_q.size() == DEPTH) || (!m_rd_ready && pend);
   endfunction

   task automatic model_edge();
      int   n;
      bit   was_full, have;
      cmd_s c, h;
      if (RESET) begin
         m_q.delete();
         m_busy = 0; m_wait_data = 0; m_inflight_rd = 0; m_rd_ready = 0; m_err = 0;
         m_wrreq = 0; m_rdreq = 0; m_asreq = 0; m_data = 0; m_rd_data = 0; m_addr = 0;
         return;
      end
      n        = int'(cpu_addr_strobe) + int'(cpu_wr_strobe) + int'(cpu_rd_strobe);
      was_full = (m_q.size() == DEPTH);
      have     = 0;
      c        = '{0, 0, 18'h0};
      if (n > 1) m_err = 1;
      if (n > 0) begin
         if (was_full) m_err = 1;
         else begin
            have = 1;
            if (cpu_addr_strobe)    c = '{1, cpu_addr_read, cpu_addr};
            else if (cpu_wr_strobe) c = '{0, 0, {10'd0, cpu_wr_data}};
            else                    c = '{2, 0, 18'h0};
         end
      end
      if (!m_busy) begin
         if (m_q.size() > 0) begin
            h = m_q.pop_front();
            if (h.kind == 0) begin m_data = h.pay[7:0]; m_wrreq = ~m_wrreq; end
            else if (h.kind == 1) begin
               m_addr = h.pay; m_asreq = ~m_asreq;
               if (h.rdf) m_rdreq = ~m_rdreq;
            end else m_rdreq = ~m_rdreq;
            m_busy = 1; m_wait_data = 0; m_inflight_rd = is_read(h);
         end
      end else if (!m_wait_data) begin
         if (m_wrreq == VDPVRAMWRACK && m_rdreq == VDPVRAMRDACK && m_asreq == VDPVRAMADDRSETACK) begin
            if (m_inflight_rd) m_wait_data = 1;
            else m_busy = 0;
         end
      end else if (vram_rd_valid) begin
         m_rd_data = vram_rd_data; m_rd_ready = 1;
         m_busy = 0; m_wait_data = 0; m_inflight_rd = 0;
      end
      if (have) begin
         m_q.push_back(c);
         if (is_read(c)) m_rd_ready = 0;
      end
   endtask

   task automatic compare_all();
      check("wrreq",   VDPVRAMWRREQ, m_wrreq);
      check("rdreq",   VDPVRAMRDREQ, m_rdreq);
      check("asreq",   VDPVRAMADDRSETREQ, m_asreq);
      check("wrdata",  VDPVRAMACCESSDATA, m_data);
      check("addr",    VDPVRAMACCESSADDRTMP, m_addr);
      check("rd_data", cpu_rd_data, m_rd_data);
      check("wait",    cpu_wait, m_cpu_wait());
      check("err",     cpu_err, m_err);
   endtask

   // ---------------- arbiter / memory responder ----------------
   bit   ack_hold = 0, auto_rd = 1;
   int   wcnt = 0, rcnt = 0, acnt = 0, dcnt = 0;
   logic [7:0] rd_byte = 8'h00;

   task automatic responder();
      if (RESET) begin
         VDPVRAMWRACK = 0; VDPVRAMRDACK = 0; VDPVRAMADDRSETACK = 0;
         wcnt = 0; rcnt = 0; acnt = 0; dcnt = 0;
         return;
      end
      if (!ack_hold) begin
         if (m_wrreq != VDPVRAMWRACK) begin
            wcnt++; if (wcnt >= 2) begin VDPVRAMWRACK = m_wrreq; wcnt = 0; end
         end
         if (m_rdreq != VDPVRAMRDACK) begin
            rcnt++; if (rcnt >= 2) begin VDPVRAMRDACK = m_rdreq; rcnt = 0; end
         end
         if (m_asreq != VDPVRAMADDRSETACK) begin
            acnt++; if (acnt >= 2) begin VDPVRAMADDRSETACK = m_asreq; acnt = 0; end
         end
      end
      if (auto_rd && m_wait_data) begin
         dcnt++;
         if (dcnt >= 2) begin vram_rd_valid = 1; vram_rd_data = rd_byte; dcnt = 0; end
      end else dcnt = 0;
   endtask

   // ---------------- toggle log ----------------
   logic       p_wr = 0, p_rd = 0, p_as = 0;
   logic [7:0] wr_log[$];
   int         wr_t[$], rd_t[$], as_t[$];

   task automatic log_toggles();
      if (!RESET) begin
         if (VDPVRAMWRREQ !== p_wr) begin
            // The arbiter must have caught up before a new write goes out.
            check("wr_after_ack", VDPVRAMWRACK, p_wr);
            wr_log.push_back(VDPVRAMACCESSDATA); wr_t.push_back(cyc);
         end
         if (VDPVRAMRDREQ !== p_rd) rd_t.push_back(cyc);
         if (VDPVRAMADDRSETREQ !== p_as) as_t.push_back(cyc);
      end
      p_wr = VDPVRAMWRREQ; p_rd = VDPVRAMRDREQ; p_as = VDPVRAMADDRSETREQ;
   endtask

   task automatic clear_logs();
      wr_log.delete(); wr_t.delete(); rd_t.delete(); as_t.delete();
   endtask

   task automatic step();
      @(posedge CLK21M);
      model_edge();
      cyc++;
      #1;
      compare_all();
      log_toggles();
      cpu_wr_strobe = 0; cpu_addr_strobe = 0; cpu_rd_strobe = 0; cpu_addr_read = 0;
      vram_rd_valid = 0;
      responder();
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((m_busy || m_q.size() != 0) && n < 200) begin step(); n++; end
      check(name, (m_busy || m_q.size() != 0), 1'b0);
      step(); step();
   endtask

   task automatic do_reset();
      RESET = 1; step(); step();
      RESET = 0; clear_logs();
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_wrreq", VDPVRAMWRREQ, 1'b0);
      check("rst_rdreq", VDPVRAMRDREQ, 1'b0);
      check("rst_asreq", VDPVRAMADDRSETREQ, 1'b0);
      check("rst_rd_data", cpu_rd_data, 8'h00);
      check("rst_wait", cpu_wait, 1'b0);
      check("rst_err", cpu_err, 1'b0);

      // Three writes in order, first one issued the edge after it is queued
      cpu_wr_strobe = 1; cpu_wr_data = 8'hA1; step();
      check("lat_not_yet", VDPVRAMWRREQ, 1'b0);
      cpu_wr_strobe = 1; cpu_wr_data = 8'hA2; step();
      check("lat_issued", VDPVRAMWRREQ, 1'b1);
      cpu_wr_strobe = 1; cpu_wr_data = 8'hA3; step();
      drain("drain_wr3");
      check("wr3_count", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         check("wr3_d0", wr_log[0], 8'hA1);
         check("wr3_d1", wr_log[1], 8'hA2);
         check("wr3_d2", wr_log[2], 8'hA3);
      end
      check("wr3_err", cpu_err, 1'b0);

      // Read-mode address set with prefetch, then a sequential read
      clear_logs();
      rd_byte = 8'h5C;
      cpu_addr_strobe = 1; cpu_addr_read = 1; cpu_addr = 18'h01234; step();
      check("aset_wait", cpu_wait, 1'b1);
      drain("drain_aset_rd");
      check("aset_rd_data", cpu_rd_data, 8'h5C);
      check("aset_addr", VDPVRAMACCESSADDRTMP, 18'h01234);
      check("aset_wait_clr", cpu_wait, 1'b0);
      check("aset_cnt", as_t.size(), 1);
      check("aset_rd_cnt", rd_t.size(), 1);
      if (as_t.size() == 1 && rd_t.size() == 1) check("aset_rd_same", as_t[0], rd_t[0]);
      rd_byte = 8'h5D;
      cpu_rd_strobe = 1; step();
      check("rd_hold_old", cpu_rd_data, 8'h5C);
      check("rd_wait", cpu_wait, 1'b1);
      drain("drain_rd");
      check("rd_next", cpu_rd_data, 8'h5D);

      // Acks held: queue fills, an over-full strobe is dropped
      do_reset();
      ack_hold = 1;
      for (int i = 0; i < 5; i++) begin
         cpu_wr_strobe = 1; cpu_wr_data = 8'h10 + 8'(i); step();
      end
      check("full_wait", cpu_wait, 1'b1);
      check("full_no_err", cpu_err, 1'b0);
      cpu_wr_strobe = 1; cpu_wr_data = 8'h1F; step();
      check("full_err", cpu_err, 1'b1);
      ack_hold = 0;
      drain("drain_full");
      check("full_wr_cnt", wr_log.size(), 5);
      if (wr_log.size() == 5) check("full_last", wr_log[4], 8'h14);
      check("full_wait_clr", cpu_wait, 1'b0);

      // Collisions: addr beats wr; wr beats rd
      do_reset();
      cpu_wr_strobe = 1; cpu_wr_data = 8'h99;
      cpu_addr_strobe = 1; cpu_addr = 18'h2AAAA; step();
      drain("drain_coll1");
      check("coll1_wr", wr_t.size(), 0);
      check("coll1_as", as_t.size(), 1);
      check("coll1_addr", VDPVRAMACCESSADDRTMP, 18'h2AAAA);
      check("coll1_err", cpu_err, 1'b1);
      do_reset();
      cpu_wr_strobe = 1; cpu_wr_data = 8'h77; cpu_rd_strobe = 1; step();
      drain("drain_coll2");
      check("coll2_wr", wr_t.size(), 1);
      check("coll2_rd", rd_t.size(), 0);
      check("coll2_data", VDPVRAMACCESSDATA, 8'h77);
      check("coll2_err", cpu_err, 1'b1);

      // Ordering: wr, set (no read), wr
      do_reset();
      cpu_wr_strobe = 1; cpu_wr_data = 8'h11; step();
      cpu_addr_strobe = 1; cpu_addr = 18'h00100; step();
      cpu_wr_strobe = 1; cpu_wr_data = 8'h22; step();
      drain("drain_order");
      check("order_wr_cnt", wr_t.size(), 2);
      check("order_as_cnt", as_t.size(), 1);
      check("order_rd_cnt", rd_t.size(), 0);
      if (wr_t.size() == 2 && as_t.size() == 1) begin
         check("order_before", wr_t[0] < as_t[0], 1'b1);
         check("order_after", as_t[0] < wr_t[1], 1'b1);
      end

      // Reset while waiting for read data; a late byte is ignored
      do_reset();
      auto_rd = 0;
      cpu_addr_strobe = 1; cpu_addr_read = 1; cpu_addr = 18'h3FFFF; step();
      begin
         int n = 0;
         while (!m_wait_data && n < 50) begin step(); n++; end
         check("reach_wait_data", m_wait_data, 1'b1);
      end
      step();
      check("wd_wait", cpu_wait, 1'b1);
      RESET = 1; step();
      check("wd_rst_wrreq", VDPVRAMWRREQ, 1'b0);
      check("wd_rst_rdreq", VDPVRAMRDREQ, 1'b0);
      check("wd_rst_asreq", VDPVRAMADDRSETREQ, 1'b0);
      check("wd_rst_wait", cpu_wait, 1'b0);
      RESET = 0; step();
      vram_rd_valid = 1; vram_rd_data = 8'hEE; step();
      step();
      check("late_valid_data", cpu_rd_data, 8'h00);
      check("late_valid_wait", cpu_wait, 1'b0);
      check("late_valid_rdreq", VDPVRAMRDREQ, 1'b0);
      auto_rd = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
